// File: rtl/icache_sa_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_sa_if
//  Purpose  : Bundle of the fetch-side and memory-side signals of icache_sa.
//             The cache connects through the 'slave' modport: it receives
//             fetch requests and flush, and issues memory reads.
//             The environment (fetch stage and memory) uses 'master'.
//  Signals  : cpu_req_addr/valid/ready   fetch request handshake
//             cpu_resp_data/valid        one-cycle instruction response
//             flush                      invalidate whole cache
//             mem_req_addr/valid/ready   memory read handshake
//             mem_req_data               memory read data
//             mem_req_wr/mem_wr_data     unused write path, driven to 0
//             hit_cnt/miss_cnt           lookup statistics
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_sa_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] cpu_req_addr;
   logic              cpu_req_valid;
   logic              cpu_req_ready;
   logic [DATA_W-1:0] cpu_resp_data;
   logic              cpu_resp_valid;
   logic              flush;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [DATA_W-1:0] mem_req_data;
   logic              mem_req_wr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [31:0]       hit_cnt;
   logic [31:0]       miss_cnt;

   modport slave (
      input  cpu_req_addr, cpu_req_valid, flush, mem_req_ready, mem_req_data,
      output cpu_req_ready, cpu_resp_data, cpu_resp_valid,
             mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
             hit_cnt, miss_cnt
   );

   modport master (
      output cpu_req_addr, cpu_req_valid, flush, mem_req_ready, mem_req_data,
      input  cpu_req_ready, cpu_resp_data, cpu_resp_valid,
             mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
             hit_cnt, miss_cnt
   );
endinterface
`default_nettype wire

// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : icache_sa
//  Purpose  : Set-associative (1 or 2 ways) read-only instruction cache with
//             multi-word line refill, LRU replacement, whole-cache flush and
//             hit/miss counters.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - icache_sa_if.slave (fetch side, memory side, flush,
//                    counters)
//  Revision : 1.0 - initial release
// ============================================================================
module icache_sa #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 64,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4
) (
   input  wire logic  clk,
   input  wire logic  rst,
   icache_sa_if.slave bus
);

   localparam int c_BOFF_W = $clog2(DATA_W / 8);
   localparam int c_WOFF_W = $clog2(LINE_WORDS);
   localparam int c_IDX_W  = $clog2(SETS);
   localparam int c_TAG_W  = ADDR_W - c_IDX_W - c_WOFF_W - c_BOFF_W;
   localparam logic [c_WOFF_W-1:0] c_LAST_WORD = c_WOFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_REFILL = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Latched fetch address without the byte offset
   logic [ADDR_W-1:c_BOFF_W] r_addr;
   logic [c_WOFF_W-1:0]      r_cnt;
   logic                     r_victim;
   logic [WAYS-1:0][SETS-1:0] r_valid;
   logic [SETS-1:0]          r_lru;      // way to evict next in each set
   logic [31:0]              r_hit_cnt;
   logic [31:0]              r_miss_cnt;
   logic                     r_flush_pend;

   logic [c_TAG_W-1:0] r_tag  [WAYS][SETS];
   logic [DATA_W-1:0]  r_data [WAYS][SETS*LINE_WORDS];

   logic [c_TAG_W-1:0]  w_tag;
   logic [c_IDX_W-1:0]  w_idx;
   logic [c_WOFF_W-1:0] w_woff;
   logic [WAYS-1:0]     w_way_hit;
   logic                w_hit;
   logic                w_hit_way;
   logic                w_victim;
   logic [DATA_W-1:0]   w_hit_word;
   logic [DATA_W-1:0]   w_resp_word;

   logic                w_flush_now;
   logic                w_ready;
   logic                w_accept;
   logic                w_resp_valid;
   logic [DATA_W-1:0]   w_resp_data;
   logic                w_mem_valid;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic                w_mem_take;
   logic                w_unused;

   assign w_tag  = r_addr[ADDR_W-1 -: c_TAG_W];
   assign w_idx  = r_addr[c_BOFF_W+c_WOFF_W +: c_IDX_W];
   assign w_woff = r_addr[c_BOFF_W +: c_WOFF_W];

   // Byte-offset bits of the fetch address carry no information
   assign w_unused = &{1'b0, bus.cpu_req_addr[c_BOFF_W-1:0]};

   for (genvar g = 0; g < WAYS; g++) begin : g_way_cmp
      assign w_way_hit[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
   end

   assign w_hit = |w_way_hit;

   if (WAYS == 2) begin : g_two_way
      assign w_hit_way = w_way_hit[WAYS-1];
      // Fill an empty way first (way 0 preferred), otherwise evict LRU way
      assign w_victim  = !r_valid[0][w_idx]      ? 1'b0 :
                         !r_valid[WAYS-1][w_idx] ? 1'b1 : r_lru[w_idx];
   end else begin : g_one_way
      assign w_hit_way = 1'b0;
      assign w_victim  = 1'b0;
   end

   assign w_hit_word  = r_data[w_hit_way][{w_idx, w_woff}];
   assign w_resp_word = r_data[r_victim][{w_idx, w_woff}];

   // ------------------------------------------------------------------
   // FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_flush_now  = 1'b0;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_resp_valid = 1'b0;
      w_resp_data  = '0;
      w_mem_valid  = 1'b0;
      w_mem_addr   = '0;
      w_mem_take   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A pending or live flush owns this cycle; no fetch is taken
            w_flush_now = bus.flush | r_flush_pend;
            w_ready     = rst & ~w_flush_now;
            w_accept    = w_ready & bus.cpu_req_valid;
            if (w_accept) begin
               w_state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (w_hit) begin
               w_resp_valid = 1'b1;
               w_resp_data  = w_hit_word;
               w_state_nxt  = S_IDLE;
            end else begin
               w_state_nxt  = S_REFILL;
            end
         end
         S_REFILL: begin
            w_mem_valid = 1'b1;
            w_mem_addr  = {w_tag, w_idx, r_cnt, {c_BOFF_W{1'b0}}};
            w_mem_take  = bus.mem_req_ready;
            if (w_mem_take && (r_cnt == c_LAST_WORD)) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_resp_valid = 1'b1;
            w_resp_data  = w_resp_word;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Control datapath: address latch, word counter, valid/LRU, counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr       <= '0;
         r_cnt        <= '0;
         r_victim     <= 1'b0;
         r_valid      <= '0;
         r_lru        <= '0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= bus.cpu_req_addr[ADDR_W-1:c_BOFF_W];
         end

         if (w_flush_now) begin
            r_valid      <= '0;
            r_lru        <= '0;
            r_flush_pend <= 1'b0;
         end else if (bus.flush && (r_state != S_IDLE)) begin
            r_flush_pend <= 1'b1;
         end

         if (r_state == S_LOOKUP) begin
            if (w_hit) begin
               r_hit_cnt    <= r_hit_cnt + 32'd1;
               r_lru[w_idx] <= ~w_hit_way;
            end else begin
               r_miss_cnt <= r_miss_cnt + 32'd1;
               r_victim   <= w_victim;
               // Victim stays invalid until its last word lands, so an
               // interrupted refill never leaves a half-filled valid line
               r_valid[w_victim][w_idx] <= 1'b0;
               r_cnt      <= '0;
            end
         end

         if (w_mem_take) begin
            r_cnt <= r_cnt + c_WOFF_W'(1);
            if (r_cnt == c_LAST_WORD) begin
               r_valid[r_victim][w_idx] <= 1'b1;
               r_lru[w_idx]             <= ~r_victim;
            end
         end
      end
   end

   // Line storage: contents are qualified by r_valid, so no reset needed
   always_ff @(posedge clk) begin
      if (w_mem_take) begin
         r_data[r_victim][{w_idx, r_cnt}] <= bus.mem_req_data;
         if (r_cnt == c_LAST_WORD) begin
            r_tag[r_victim][w_idx] <= w_tag;
         end
      end
   end

   assign bus.cpu_req_ready  = w_ready;
   assign bus.cpu_resp_valid = w_resp_valid;
   assign bus.cpu_resp_data  = w_resp_data;
   assign bus.mem_req_valid  = w_mem_valid;
   assign bus.mem_req_addr   = w_mem_addr;
   assign bus.mem_req_wr     = 1'b0;
   assign bus.mem_wr_data    = '0;
   assign bus.hit_cnt        = r_hit_cnt;
   assign bus.miss_cnt       = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_sa
//  Purpose  : Self-checking bench for icache_sa. A recency-list cache model
//             predicts hit/miss, counters, memory traffic and responses; a
//             single compare process checks the DUT every cycle, and a few
//             literal expectations pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_sa;

   localparam int SETS = 64;
   localparam int WAYS = 2;
   localparam int LW   = 4;

   logic clk;
   logic rst;

   icache_sa_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   icache_sa #(
      .ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: fixed function of the word address
   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   assign bus.mem_req_data = memword(bus.mem_req_addr);

   // ---------------- model state ----------------
   logic [31:0] m_q [SETS][$];   // per set: tags, most recently used first
   logic [31:0] m_hit, m_miss;
   bit          last_hit;

   // ---------------- expectations ----------------
   bit          chk_en;
   bit          exp_in_rst;
   bit          exp_ready, exp_resp_valid, exp_mem_valid;
   logic [31:0] exp_resp_data, exp_mem_addr;

   int n_pass, n_chk;
   int cyc_no, last_resp_cyc, n_mem_acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   always @(posedge clk) begin
      cyc_no++;
      if (rst && bus.mem_req_valid && bus.mem_req_ready) n_mem_acc++;
   end

   // Single compare process, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("cpu_req_ready", bus.cpu_req_ready, exp_ready);
         check("cpu_resp_valid", bus.cpu_resp_valid, exp_resp_valid);
         if (exp_resp_valid) check("cpu_resp_data", bus.cpu_resp_data, exp_resp_data);
         check("mem_req_valid", bus.mem_req_valid, exp_mem_valid);
         if (exp_mem_valid) check("mem_req_addr", bus.mem_req_addr, exp_mem_addr);
         check("hit_cnt", bus.hit_cnt, m_hit);
         check("miss_cnt", bus.miss_cnt, m_miss);
         check("mem_req_wr", bus.mem_req_wr, 0);
         check("mem_wr_data", bus.mem_wr_data, 0);
         if (exp_in_rst) begin
            check("rst_resp_data", bus.cpu_resp_data, 0);
            check("rst_mem_addr", bus.mem_req_addr, 0);
         end
         if (bus.cpu_resp_valid) last_resp_cyc = cyc_no;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) m_q[s].delete();
   endtask

   function automatic int model_find(input int s, input logic [31:0] t);
      for (int i = 0; i < m_q[s].size(); i++) if (m_q[s][i] == t) return i;
      return -1;
   endfunction

   task automatic async_reset_now();
      #1;
      rst = 1'b0;
      exp_in_rst = 1'b1;
      exp_ready = 1'b0; exp_resp_valid = 1'b0; exp_mem_valid = 1'b0;
      m_hit = 0; m_miss = 0;
      model_clear();
      #1;
      check("async_mem_valid_drop", bus.mem_req_valid, 0);
      cyc();
      cyc();
      rst = 1'b1;
      exp_in_rst = 1'b0;
      exp_ready = 1'b1;
   endtask

   // One fetch, started at posedge+1 of an IDLE cycle.
   // waits   : memory wait cycles before each refill word
   // flush_k : raise flush in the cycle word flush_k is accepted (-1: none)
   // rst_k   : async reset after rst_k words accepted (-1: none)
   task automatic fetch(input logic [31:0] a, input int waits,
                        input int flush_k, input int rst_k);
      int          s, pos;
      logic [31:0] t, base;
      s    = int'((a / (4 * LW)) % SETS);
      t    = a / (4 * LW * SETS);
      base = a - (a % (4 * LW));
      pos  = model_find(s, t);
      last_hit = (pos >= 0);

      bus.cpu_req_addr = a; bus.cpu_req_valid = 1'b1;
      exp_ready = 1'b1; exp_resp_valid = 1'b0; exp_mem_valid = 1'b0;
      cyc();
      bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = 32'hDEAD_BEE0;
      exp_ready = 1'b0;
      if (last_hit) begin
         exp_resp_valid = 1'b1; exp_resp_data = memword(a & ~32'h3);
         cyc();
         m_hit++;
         m_q[s].delete(pos); m_q[s].push_front(t);
         exp_resp_valid = 1'b0; exp_ready = 1'b1;
         return;
      end
      cyc();
      m_miss++;
      if (m_q[s].size() == WAYS) void'(m_q[s].pop_back());
      for (int k = 0; k < LW; k++) begin
         exp_mem_valid = 1'b1; exp_mem_addr = base + 32'(4 * k);
         for (int w = 0; w < waits; w++) begin
            bus.mem_req_ready = 1'b0;
            cyc();
         end
         bus.mem_req_ready = 1'b1;
         if (k == flush_k) bus.flush = 1'b1;
         cyc();
         bus.flush = 1'b0;
         if (k + 1 == rst_k) begin
            async_reset_now();
            return;
         end
      end
      exp_mem_valid = 1'b0;
      exp_resp_valid = 1'b1; exp_resp_data = memword(a & ~32'h3);
      m_q[s].push_front(t);
      cyc();
      exp_resp_valid = 1'b0;
      if (flush_k >= 0) begin
         exp_ready = 1'b0;        // deferred flush takes this IDLE cycle
         cyc();
         model_clear();
      end
      exp_ready = 1'b1;
   endtask

   task automatic flush_idle();
      bus.flush = 1'b1; exp_ready = 1'b0;
      cyc();
      model_clear();
      bus.flush = 1'b0; exp_ready = 1'b1;
   endtask

   int t0, acc0;

   initial begin
      n_pass = 0; n_chk = 0; cyc_no = 0; n_mem_acc = 0; last_resp_cyc = 0;
      m_hit = 0; m_miss = 0; last_hit = 1'b0;
      bus.cpu_req_addr = '0; bus.cpu_req_valid = 1'b0;
      bus.flush = 1'b0; bus.mem_req_ready = 1'b1;
      exp_in_rst = 1'b1; exp_ready = 1'b0; exp_resp_valid = 1'b0;
      exp_mem_valid = 1'b0; exp_resp_data = '0; exp_mem_addr = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      chk_en = 1'b1;
      cyc(); cyc();
      rst = 1'b1; exp_in_rst = 1'b0; exp_ready = 1'b1;
      cyc();

      // Cold miss
      t0 = cyc_no; acc0 = n_mem_acc;
      fetch(32'h100, 0, -1, -1);
      check("cold_is_miss", last_hit, 0);
      check("cold_resp_latency", last_resp_cyc - t0, 6);
      check("cold_mem_words", n_mem_acc - acc0, 4);
      check("cold_miss_cnt", bus.miss_cnt, 1);

      // Hits in the same line
      acc0 = n_mem_acc;
      t0 = cyc_no; fetch(32'h104, 0, -1, -1);
      check("hit_latency", last_resp_cyc - t0, 1);
      fetch(32'h10C, 0, -1, -1);
      check("line_hit_cnt", bus.hit_cnt, 2);
      check("line_hit_no_mem", n_mem_acc - acc0, 0);

      // LRU in set 0
      fetch(32'h0000, 0, -1, -1);
      fetch(32'h1000, 0, -1, -1);
      fetch(32'h0000, 0, -1, -1);
      check("lru_A_hit", last_hit, 1);
      fetch(32'h2000, 0, -1, -1);
      fetch(32'h0000, 0, -1, -1);
      check("lru_A_still_hit", last_hit, 1);
      fetch(32'h1000, 0, -1, -1);
      check("lru_B_evicted", last_hit, 0);
      check("lru_miss_cnt", bus.miss_cnt, 5);

      // Wait states
      fetch(32'h3048, 3, -1, -1);
      check("wait_miss_cnt", bus.miss_cnt, 6);
      check("wait_hit_cnt", bus.hit_cnt, 4);
      fetch(32'h3044, 0, -1, -1);
      check("wait_line_hit", last_hit, 1);

      // Flush mid-refill
      fetch(32'h500, 0, 1, -1);
      check("flush_refill_miss", last_hit, 0);
      fetch(32'h500, 0, -1, -1);
      check("after_flush_miss", last_hit, 0);
      fetch(32'h104, 0, -1, -1);
      check("after_flush_old_line_miss", last_hit, 0);

      // Flush in IDLE
      flush_idle();
      fetch(32'h500, 1, -1, -1);
      check("idle_flush_miss", last_hit, 0);

      // Async reset mid-refill, then the same fetch refills fully
      fetch(32'h700, 0, -1, 2);
      cyc();
      acc0 = n_mem_acc;
      fetch(32'h700, 0, -1, -1);
      check("post_rst_miss", last_hit, 0);
      check("post_rst_words", n_mem_acc - acc0, 4);
      check("post_rst_miss_cnt", bus.miss_cnt, 1);
      fetch(32'h708, 0, -1, -1);
      check("post_rst_hit", bus.hit_cnt, 1);

      cyc();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
